csa_bist_pattern_gen: RTL and testbench

//  Built-in self-test pattern source for the replicated carry-select adder slices.

---
 rtl/csa_bist_pkg.sv | 32 +++
 rtl/csa_bist_pattern_gen_lfsr.sv | 27 ++
 rtl/csa_bist_pattern_gen.sv | 130 +++++++++++++
 tb/tb_csa_bist_pattern_gen.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_bist_pkg.sv
// Shared types and constants for the carry-select adder BIST pattern source.
package csa_bist_pkg;

  localparam int DEF_OP_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    APPLY,
    STROBE,
    DONE
  } state_t;

  // Feedback tap mask for a maximal-length Fibonacci LFSR of the given width.
  // Bit i set means vec[i] feeds the XOR that becomes the new LSB.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] taps;
    case (width)
      3:       taps = 32'h0000_0006;  // x^3+x^2+1
      5:       taps = 32'h0000_0014;  // x^5+x^3+1
      7:       taps = 32'h0000_0060;  // x^7+x^6+1
      9:       taps = 32'h0000_0110;  // x^9+x^5+1
      11:      taps = 32'h0000_0500;  // x^11+x^9+1
      13:      taps = 32'h0000_100D;  // x^13+x^4+x^3+x+1
      15:      taps = 32'h0000_6000;  // x^15+x^14+1
      17:      taps = 32'h0001_2000;  // x^17+x^14+1
      default: taps = 32'h0000_0500;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/csa_bist_pattern_gen_lfsr.sv
// Next-vector logic: binary up-counter or Fibonacci LFSR, plus the run start value.
module csa_bist_lfsr
  import csa_bist_pkg::*;
#(
  parameter int            VW         = 11,
  parameter logic [VW-1:0] SEED       = {{(VW-1){1'b0}}, 1'b1},
  parameter int            EXHAUSTIVE = 1
) (
  input  logic [VW-1:0] cur,
  output logic [VW-1:0] nxt,
  output logic [VW-1:0] first
);

  localparam logic [31:0] TAP_ALL = lfsr_taps(VW);
  localparam logic [VW-1:0] TAPS  = TAP_ALL[VW-1:0];

  // Select the successor of the current vector and the value a run starts from.
  always_comb begin
    nxt   = cur + VW'(1);
    first = '0;
    if (EXHAUSTIVE == 0) begin
      nxt   = {cur[VW-2:0], ^(cur & TAPS)};
      first = SEED;
    end
  end

endmodule

// File: rtl/csa_bist_pattern_gen.sv
// BIST pattern source: init pulse, then operand vectors with golden sum and a test strobe each.
//
// state  | meaning
// IDLE   | waiting for start; last run's outputs and done are held
// INIT   | comparator clear pulse on init
// APPLY  | vector stable, settle counter running (frozen by hold)
// STROBE | test pulse, vector still stable
// DONE   | run finished, busy dropped, done raised
module csa_bist_pattern_gen
  import csa_bist_pkg::*;
#(
  parameter int                OP_W       = DEF_OP_W,
  parameter int                NUM_VEC    = 2048,
  parameter int                SETTLE     = 2,
  parameter int                EXHAUSTIVE = 1,
  parameter logic [2*OP_W:0]   SEED       = {{(2*OP_W){1'b0}}, 1'b1},
  localparam int               IDX_W      = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              start,
  input  logic              hold,
  output logic [OP_W-1:0]   a,
  output logic [OP_W-1:0]   b,
  output logic              cin,
  output logic [OP_W:0]     desired_output,
  output logic              init,
  output logic              test,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  vec_idx
);

  localparam int VW    = 2*OP_W + 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  if (SEED == '0 || NUM_VEC < 1 || NUM_VEC > (2**VW) || SETTLE < 1) begin : g_bad_params
    $fatal(1, "csa_bist_pattern_gen: SEED must be nonzero, NUM_VEC in 1..2^(2*OP_W+1), SETTLE >= 1");
  end

  state_t          state;
  logic [VW-1:0]   vec;
  logic [VW-1:0]   vec_nxt;
  logic [VW-1:0]   vec_first;
  logic [CNT_W-1:0] cnt;

  csa_bist_lfsr #(
    .VW         (VW),
    .SEED       (SEED),
    .EXHAUSTIVE (EXHAUSTIVE)
  ) u_next (
    .cur   (vec),
    .nxt   (vec_nxt),
    .first (vec_first)
  );

  // Golden sum is formed from the vector being loaded so both land in the same flop cycle.
  function automatic logic [OP_W:0] golden(input logic [VW-1:0] v);
    return {1'b0, v[VW-1:OP_W+1]} + {1'b0, v[OP_W:1]} + {{OP_W{1'b0}}, v[0]};
  endfunction

  assign a   = vec[VW-1:OP_W+1];
  assign b   = vec[OP_W:1];
  assign cin = vec[0];

  // Sequencer, settle counter and all registered outputs.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state          <= IDLE;
      vec            <= '0;
      desired_output <= '0;
      init           <= 1'b0;
      test           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      vec_idx        <= '0;
      cnt            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state          <= INIT;
            done           <= 1'b0;
            busy           <= 1'b1;
            init           <= 1'b1;
            vec            <= vec_first;
            desired_output <= golden(vec_first);
            vec_idx        <= '0;
          end
        end
        INIT: begin
          init  <= 1'b0;
          cnt   <= CNT_W'(SETTLE);
          state <= APPLY;
        end
        APPLY: begin
          if (!hold) begin
            if (cnt == CNT_W'(1)) begin
              test  <= 1'b1;
              state <= STROBE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        STROBE: begin
          test <= 1'b0;
          if (vec_idx == IDX_W'(NUM_VEC - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            vec            <= vec_nxt;
            desired_output <= golden(vec_nxt);
            vec_idx        <= vec_idx + IDX_W'(1);
            cnt            <= CNT_W'(SETTLE);
            state          <= APPLY;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_bist_pattern_gen.sv
// Scoreboard bench: small exhaustive run, full exhaustive run and full LFSR run.
module tb_csa_bist_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int a;
    int b;
    int cin;
    int sum;
    int idx;
    int gap;
  } exp_t;

  exp_t sq[$];
  exp_t fq[$];
  exp_t lq[$];

  // small: NUM_VEC=4, SETTLE=2, exhaustive
  logic       s_rst = 1'b1, s_start = 1'b0, s_hold = 1'b0;
  logic [4:0] s_a, s_b;
  logic       s_cin, s_init, s_test, s_busy, s_done;
  logic [5:0] s_d;
  logic [1:0] s_idx;

  // full: NUM_VEC=2048, SETTLE=1, exhaustive
  logic       f_rst = 1'b1, f_start = 1'b0, f_hold = 1'b0;
  logic [4:0] f_a, f_b;
  logic       f_cin, f_init, f_test, f_busy, f_done;
  logic [5:0] f_d;
  logic [10:0] f_idx;

  // lfsr: NUM_VEC=2047, SETTLE=1, seed 001
  logic       l_rst = 1'b1, l_start = 1'b0, l_hold = 1'b0;
  logic [4:0] l_a, l_b;
  logic       l_cin, l_init, l_test, l_busy, l_done;
  logic [5:0] l_d;
  logic [10:0] l_idx;

  csa_bist_pattern_gen #(.OP_W(5), .NUM_VEC(4), .SETTLE(2), .EXHAUSTIVE(1), .SEED(11'h001)) u_small (
    .clk(clk), .init_n(s_rst), .start(s_start), .hold(s_hold),
    .a(s_a), .b(s_b), .cin(s_cin), .desired_output(s_d),
    .init(s_init), .test(s_test), .busy(s_busy), .done(s_done), .vec_idx(s_idx));

  csa_bist_pattern_gen #(.OP_W(5), .NUM_VEC(2048), .SETTLE(1), .EXHAUSTIVE(1), .SEED(11'h001)) u_full (
    .clk(clk), .init_n(f_rst), .start(f_start), .hold(f_hold),
    .a(f_a), .b(f_b), .cin(f_cin), .desired_output(f_d),
    .init(f_init), .test(f_test), .busy(f_busy), .done(f_done), .vec_idx(f_idx));

  csa_bist_pattern_gen #(.OP_W(5), .NUM_VEC(2047), .SETTLE(1), .EXHAUSTIVE(0), .SEED(11'h001)) u_lfsr (
    .clk(clk), .init_n(l_rst), .start(l_start), .hold(l_hold),
    .a(l_a), .b(l_b), .cin(l_cin), .desired_output(l_d),
    .init(l_init), .test(l_test), .busy(l_busy), .done(l_done), .vec_idx(l_idx));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: the k-th vector of a run, from the stated source rules.
  function automatic int lfsr_step(input int v);
    return ((v << 1) & 'h7FF) | (((v >> 10) ^ (v >> 8)) & 1);
  endfunction

  function automatic exp_t make_exp(input int v, input int k, input int gap);
    exp_t e;
    e.a   = (v >> 6) & 31;
    e.b   = (v >> 1) & 31;
    e.cin = v & 1;
    e.sum = e.a + e.b + e.cin;
    e.idx = k;
    e.gap = gap;
    return e;
  endfunction

  // which: 0 small, 1 full, 2 lfsr. hold_k/hold_len add extra delay to one vector.
  task automatic push_run(input int which, input int n, input bit exh, input int gap,
                          input int hold_k, input int hold_len);
    int v;
    v = exh ? 0 : 1;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e = make_exp(v, k, gap + ((k == hold_k) ? hold_len : 0));
      case (which)
        0: sq.push_back(e);
        1: fq.push_back(e);
        default: lq.push_back(e);
      endcase
      v = exh ? ((v + 1) % 2048) : lfsr_step(v);
    end
  endtask

  task automatic check_vec(input string tag, input exp_t e, input int a, input int b,
                           input int cin, input int d, input int idx, input int gap);
    chk({tag, "_a"},    a,   e.a);
    chk({tag, "_b"},    b,   e.b);
    chk({tag, "_cin"},  cin, e.cin);
    chk({tag, "_sum"},  d,   e.sum);
    chk({tag, "_idx"},  idx, e.idx);
    chk({tag, "_gap"},  gap, e.gap);
  endtask

  // Monitor: small instance.
  logic s_init_prev = 1'b0, s_test_prev = 1'b0;
  int   s_last = 0, s_init_cnt = 0;
  always @(negedge clk) begin
    if (s_init) begin
      chk("s_init_one_cycle", s_init_prev, 0);
      s_init_cnt++;
      s_last = cyc;
    end
    if (s_test) begin
      chk("s_test_one_cycle", s_test_prev, 0);
      if (sq.size() == 0) fail_now("s_unexpected_test");
      else check_vec("s", sq.pop_front(), s_a, s_b, s_cin, s_d, s_idx, cyc - s_last);
      s_last = cyc;
    end
    s_init_prev = s_init;
    s_test_prev = s_test;
  end

  // Monitor: full exhaustive instance.
  int f_last = 0;
  always @(negedge clk) begin
    if (f_init) f_last = cyc;
    if (f_test) begin
      if (fq.size() == 0) fail_now("f_unexpected_test");
      else check_vec("f", fq.pop_front(), f_a, f_b, f_cin, f_d, f_idx, cyc - f_last);
      f_last = cyc;
    end
  end

  // Monitor: LFSR instance, plus distinctness of every applied vector.
  int l_last = 0;
  bit l_seen [int];
  always @(negedge clk) begin
    int v;
    if (l_init) l_last = cyc;
    if (l_test) begin
      v = {l_a, l_b, l_cin};
      if (l_seen.exists(v)) fail_now($sformatf("l_repeat_vector_%0h", v));
      l_seen[v] = 1'b1;
      if (lq.size() == 0) fail_now("l_unexpected_test");
      else check_vec("l", lq.pop_front(), l_a, l_b, l_cin, l_d, l_idx, cyc - l_last);
      l_last = cyc;
    end
  end

  task automatic s_all_zero(input string tag);
    chk({tag, "_a"}, s_a, 0);
    chk({tag, "_b"}, s_b, 0);
    chk({tag, "_cin"}, s_cin, 0);
    chk({tag, "_sum"}, s_d, 0);
    chk({tag, "_init"}, s_init, 0);
    chk({tag, "_test"}, s_test, 0);
    chk({tag, "_busy"}, s_busy, 0);
    chk({tag, "_done"}, s_done, 0);
    chk({tag, "_idx"}, s_idx, 0);
  endtask

  task automatic s_wait_done(input string tag);
    int k;
    k = 0;
    while (!s_done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_reached_done"}, s_done, 1);
  endtask

  task automatic s_pulse_start();
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    #2;
    s_rst = 1'b0; f_rst = 1'b0; l_rst = 1'b0;
    repeat (3) @(negedge clk);
    s_all_zero("reset");
    chk("reset_f_busy", f_busy, 0);
    chk("reset_l_done", l_done, 0);
    s_rst = 1'b1; f_rst = 1'b1; l_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Run A: plain run, with a start pulse while busy that must be ignored.
    push_run(0, 4, 1'b1, 3, -1, 0);
    s_init_cnt = 0;
    s_pulse_start();
    repeat (3) @(negedge clk);
    chk("runA_busy", s_busy, 1);
    s_pulse_start();
    s_wait_done("runA");
    chk("runA_busy_at_done", s_busy, 0);
    chk("runA_test_at_done", s_test, 0);
    chk("runA_last_vec", {s_a, s_b, s_cin}, 3);
    chk("runA_last_sum", s_d, 2);
    chk("runA_queue_empty", sq.size(), 0);
    chk("runA_init_pulses", s_init_cnt, 1);

    // Run B: start held from DONE (accepted only in IDLE), hold 5 cycles on vector 2.
    push_run(0, 4, 1'b1, 3, 2, 5);
    s_init_cnt = 0;
    s_start = 1'b1;
    @(negedge clk);
    chk("runB_done_kept_in_idle", s_done, 1);
    chk("runB_no_init_from_done", s_init, 0);
    @(negedge clk);
    s_start = 1'b0;
    chk("runB_done_cleared", s_done, 0);
    chk("runB_init_pulse", s_init, 1);
    chk("runB_busy", s_busy, 1);
    chk("runB_restart_vec", {s_a, s_b, s_cin}, 0);
    k = 0;
    while (s_idx != 2'd2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("runB_reach_vec2", s_idx, 2);
    s_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("runB_hold_vec", {s_a, s_b, s_cin}, 2);
      chk("runB_hold_sum", s_d, 1);
      chk("runB_hold_no_test", s_test, 0);
    end
    s_hold = 1'b0;
    s_wait_done("runB");
    chk("runB_queue_empty", sq.size(), 0);
    chk("runB_init_pulses", s_init_cnt, 1);
    repeat (2) @(negedge clk);

    // Run C: reset during APPLY of vector 3, then a complete replay.
    push_run(0, 4, 1'b1, 3, -1, 0);
    s_pulse_start();
    k = 0;
    while (s_idx != 2'd3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("runC_reach_vec3", s_idx, 3);
    #1 s_rst = 1'b0;
    #1 s_all_zero("midrun_reset");
    sq.delete();
    repeat (2) @(negedge clk);
    s_rst = 1'b1;
    @(negedge clk);
    push_run(0, 4, 1'b1, 3, -1, 0);
    s_init_cnt = 0;
    s_pulse_start();
    s_wait_done("runD");
    chk("runD_queue_empty", sq.size(), 0);
    chk("runD_init_pulses", s_init_cnt, 1);
    repeat (3) @(negedge clk);
    chk("runD_done_sticky", s_done, 1);
    chk("runD_busy_idle", s_busy, 0);

    // Full exhaustive run.
    push_run(1, 2048, 1'b1, 2, -1, 0);
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    k = 0;
    while (!f_done && k < 6000) begin
      @(negedge clk);
      k++;
    end
    chk("full_reached_done", f_done, 1);
    chk("full_final_a", f_a, 31);
    chk("full_final_b", f_b, 31);
    chk("full_final_cin", f_cin, 1);
    chk("full_final_sum", f_d, 63);
    chk("full_queue_empty", fq.size(), 0);

    // Full LFSR run.
    push_run(2, 2047, 1'b0, 2, -1, 0);
    l_start = 1'b1;
    @(negedge clk);
    l_start = 1'b0;
    k = 0;
    while (!l_done && k < 6000) begin
      @(negedge clk);
      k++;
    end
    chk("lfsr_reached_done", l_done, 1);
    chk("lfsr_distinct_count", l_seen.num(), 2047);
    chk("lfsr_queue_empty", lq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
